// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for the 4:1 x/y coordinate mux.
// One requester is granted at a time and its index drives the mux select.
// The grant is held until the burst ends (last_in) or the beat limit is hit.
// On release the next grant is chosen in the same cycle, so there is no bubble.
module mux_rr_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [3:0] req_in,
  input  logic [3:0] last_in,
  input  logic       ready_in,
  output logic [1:0] sel_out,
  output logic [3:0] grant_out,
  output logic       valid_out,
  output logic [3:0] ack_out,
  output logic       busy_out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [3:0]       grant_reg, grant_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic       beat;
  logic       limit_hit;
  logic       release_now;
  logic [1:0] rel_start;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;

  // First requester found searching start, start+1, start+2, start+3 (mod 4).
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign valid_out   = busy_reg & req_in[sel_reg];
  assign beat        = valid_out & ready_in;
  assign limit_hit   = (cnt_reg == CNT_W'(MAX_BURST - 1));
  assign release_now = beat & (last_in[sel_reg] | limit_hit);

  // Searching from the slot after the releasing requester puts that requester
  // last in order, so it only wins again when it is the sole requester.
  assign rel_start = sel_reg + 2'd1;
  assign idle_pick = rr_pick(req_in, ptr_reg);
  assign rel_pick  = rr_pick(req_in, rel_start);

  // Per-requester accept strobes follow the registered grant.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
      assign ack_out[gi] = grant_reg[gi] & beat;
    end
  endgenerate

  assign sel_out   = sel_reg;
  assign grant_out = grant_reg;
  assign busy_out  = busy_reg;

  // State, pointer, grant and beat counter registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
      grant_reg <= 4'b0000;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: grant from idle, count beats, release and re-arbitrate.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (idle_pick[2]) begin
          state_next = GRANT;
          sel_next   = idle_pick[1:0];
          grant_next = 4'(1) << idle_pick[1:0];
          busy_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // A single release per beat, even if last and the limit coincide.
          ptr_next = rel_start;
          cnt_next = '0;
          if (rel_pick[2]) begin
            sel_next   = rel_pick[1:0];
            grant_next = 4'(1) << rel_pick[1:0];
          end else begin
            // sel_out keeps its last value while idle.
            state_next = IDLE;
            grant_next = 4'b0000;
            busy_next  = 1'b0;
          end
        end else if (beat) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'b0000;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with a beat scoreboard.
// Each scenario queues the requester index expected for every accepted beat;
// a negedge monitor pops one entry per beat and checks sel_out and ack_out.
module tb_mux_rr_arbiter;

  logic       clk_in;
  logic       rst_n_in;
  logic [3:0] req_in;
  logic [3:0] last_in;
  logic       ready_in;
  logic [1:0] sel_out;
  logic [3:0] grant_out;
  logic       valid_out;
  logic [3:0] ack_out;
  logic       busy_out;

  int err_cnt = 0;
  int chk_cnt = 0;
  int beat_no = 0;
  int sb_exp;
  int sb_q[$];

  mux_rr_arbiter #(.MAX_BURST(16), .CNT_W(5)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .req_in    (req_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .sel_out   (sel_out),
    .grant_out (grant_out),
    .valid_out (valid_out),
    .ack_out   (ack_out),
    .busy_out  (busy_out)
  );

  // Free-running clock, period 10.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  task automatic drive(input logic [3:0] req, input logic [3:0] last, input logic rdy);
    req_in   = req;
    last_in  = last;
    ready_in = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_n(input int idx, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(idx);
  endtask

  task automatic apply_reset();
    rst_n_in = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_grant", 32'(grant_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  // Scoreboard monitor: one line per accepted beat.
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_exp = sb_q.pop_front();
        beat_no++;
        $display("beat %0d: sel=%0d ack=%b exp_idx=%0d", beat_no, sel_out, ack_out, sb_exp);
        check("sb_sel", 32'(sel_out), 32'(sb_exp));
        check("sb_ack", 32'(ack_out), 32'(oh(sb_exp)));
      end
    end
  end

  int       t2_ord[5] = '{0, 1, 2, 3, 0};
  logic     t4_rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] t5_req;

  initial begin
    rst_n_in = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);
    // Reset state with every request asserted.
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst0_sel", 32'(sel_out), 32'd0);
    check("rst0_grant", 32'(grant_out), 32'd0);
    check("rst0_busy", 32'(busy_out), 32'd0);
    check("rst0_valid", 32'(valid_out), 32'd0);
    check("rst0_ack", 32'(ack_out), 32'd0);

    // 1: single requester, last on beat 3; sole requester is granted again.
    apply_reset();
    push_n(0, 3);
    drive(4'b0001, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t1_latency", 32'(grant_out), 32'd0);
    next_cycle();
    @(negedge clk_in);
    check("t1_grant", 32'(grant_out), 32'b0001);
    next_cycle();
    @(negedge clk_in);
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    @(negedge clk_in);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t1_regrant", 32'(grant_out), 32'b0001);
    check("t1_valid", 32'(valid_out), 32'd0);
    check("t1_drain", 32'(sb_q.size()), 32'd0);

    // 2: all requesting, every beat last: strict rotation with no bubbles.
    apply_reset();
    for (int i = 0; i < 5; i++) sb_q.push_back(t2_ord[i]);
    drive(4'b1111, 4'b1111, 1'b1);
    @(negedge clk_in);
    check("t2_idle", 32'(busy_out), 32'd0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge clk_in);
      check("t2_busy", 32'(busy_out), 32'd1);
      check("t2_grant", 32'(grant_out), 32'(oh(t2_ord[k])));
    end
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t2_wrap", 32'(grant_out), 32'b0010);
    check("t2_drain", 32'(sb_q.size()), 32'd0);

    // 3: no last: forced release after 16 beats, twice, then requester 3.
    apply_reset();
    push_n(2, 32);
    push_n(3, 1);
    drive(4'b0100, 4'b0000, 1'b1);
    @(negedge clk_in);
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      @(negedge clk_in);
    end
    next_cycle();
    drive(4'b1100, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t3_regrant", 32'(grant_out), 32'b0100);
    for (int k = 18; k <= 32; k++) begin
      next_cycle();
      @(negedge clk_in);
    end
    next_cycle();
    @(negedge clk_in);
    check("t3_forced", 32'(grant_out), 32'b1000);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t3_drain", 32'(sb_q.size()), 32'd0);

    // 4: requester 1 with ready toggling; acks only on ready cycles.
    apply_reset();
    push_n(1, 3);
    drive(4'b0010, 4'b0000, 1'b1);
    @(negedge clk_in);
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      drive(4'b0010, (k == 5) ? 4'b0010 : 4'b0000, t4_rdy[k]);
      @(negedge clk_in);
      check("t4_ack", 32'(ack_out), t4_rdy[k] ? 32'b0010 : 32'd0);
      check("t4_hold", 32'(grant_out), 32'b0010);
    end
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t4_drain", 32'(sb_q.size()), 32'd0);

    // 5: requester 2 stalls 3 cycles; limit still needs 16 real beats.
    apply_reset();
    push_n(2, 16);
    push_n(3, 1);
    drive(4'b1100, 4'b0000, 1'b1);
    @(negedge clk_in);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      t5_req = (k >= 6 && k <= 8) ? 4'b1000 : 4'b1100;
      drive(t5_req, 4'b0000, 1'b1);
      @(negedge clk_in);
      if (k >= 6 && k <= 8) begin
        check("t5_valid", 32'(valid_out), 32'd0);
        check("t5_ack", 32'(ack_out), 32'd0);
        check("t5_hold", 32'(grant_out), 32'b0100);
      end
      if (k == 20) check("t5_limit", 32'(grant_out), 32'b1000);
    end
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t5_drain", 32'(sb_q.size()), 32'd0);

    // 6: async reset on beat 5 of a burst; pointer restarts at 0.
    apply_reset();
    sb_q.push_back(0);
    push_n(1, 5);
    drive(4'b0011, 4'b0001, 1'b1);
    @(negedge clk_in);
    next_cycle();
    @(negedge clk_in);
    next_cycle();
    drive(4'b0011, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t6_grant1", 32'(grant_out), 32'b0010);
    for (int k = 3; k <= 6; k++) begin
      next_cycle();
      @(negedge clk_in);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant_out), 32'd0);
    check("t6_rst_busy", 32'(busy_out), 32'd0);
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_sel", 32'(sel_out), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    sb_q.push_back(0);
    @(negedge clk_in);
    check("t6_idle", 32'(busy_out), 32'd0);
    next_cycle();
    @(negedge clk_in);
    check("t6_ptr", 32'(grant_out), 32'b0001);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    @(negedge clk_in);
    check("t6_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
